// File: rtl/dir_ctrl.sv
// dir_ctrl: debounces four direction buttons and feeds legal turns through a
// 2-deep queue that is drained one entry per unpaused move tick.
module dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W = 20
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic [3:0] BTN,
    input  logic       mv_tick,
    input  logic       pause,
    output logic [1:0] dir,
    output logic       dir_changed,
    output logic [1:0] queue_level
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       r_sync1, r_sync2, r_db, r_db_d, r_press;
    logic [CNT_W-1:0] r_cnt [4];
    logic [1:0]       r_fifo [2];
    logic             r_wr_ptr, r_rd_ptr;
    logic [1:0]       r_level, r_dir;
    logic             r_changed;
    logic             w_has, w_legal, w_pop, w_push;
    logic [1:0]       w_cand, w_ref;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_d  <= '0;
            r_press <= '0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= BTN;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            r_press <= r_db & ~r_db_d;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_db[i]) r_cnt[i] <= '0;
                else if (r_cnt[i] == CNT_MAX) begin
                    r_cnt[i] <= '0;
                    r_db[i]  <= ~r_db[i];
                end else r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    // The newest queued turn is the heading a new request must be legal against.
    assign w_has   = |r_press;
    assign w_cand  = r_press[0] ? 2'b00 : r_press[1] ? 2'b01 : r_press[2] ? 2'b10 : 2'b11;
    assign w_ref   = (r_level != 2'd0) ? r_fifo[~r_wr_ptr] : r_dir;
    assign w_legal = w_has && (w_cand != w_ref) && (w_cand != ~w_ref);
    assign w_pop   = mv_tick && !pause && (r_level != 2'd0);
    assign w_push  = w_legal && ((r_level != 2'd2) || w_pop);

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_level   <= '0;
            r_dir     <= 2'b10;
            r_changed <= 1'b0;
        end else begin
            r_changed <= w_pop;
            r_level   <= r_level + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop) begin
                r_dir    <= r_fifo[r_rd_ptr];
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_cand;
                r_wr_ptr         <= ~r_wr_ptr;
            end
        end
    end

    assign dir         = r_dir;
    assign dir_changed = r_changed;
    assign queue_level = r_level;
endmodule

// File: doc/dir_ctrl.md
DIR_CTRL -- requirements
Module: dir_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the number of consecutive cycles an input must hold to be accepted (10 ms at 100 MHz).
REQ-003 Parameter CNT_W, default 20, SHALL set the debounce counter width; 2^CNT_W SHALL be at least DEBOUNCE_CYCLES.
REQ-004 CLK100MHZ  in  1  SHALL be the system clock; all state SHALL change on its rising edge.
REQ-005 CPU_RESETN  in  1  SHALL be the asynchronous active-low reset.
REQ-006 BTN  in  4  SHALL be the raw asynchronous buttons: bit0 up, bit1 left, bit2 right, bit3 down.
REQ-007 mv_tick  in  1  SHALL be a one-cycle move-step strobe, synchronous to CLK100MHZ.
REQ-008 pause  in  1  SHALL be a level input; high freezes direction updates.
REQ-009 dir  out  2  SHALL be the current heading: 00 up, 01 left, 10 right, 11 down.
REQ-010 dir_changed  out  1  SHALL be a one-cycle pulse each time dir takes a new value.
REQ-011 queue_level  out  2  SHALL be the number of pending direction requests (0..2).

Function
REQ-012 Each BTN bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Debounce, per button:
- A counter SHALL count while the synchronized input differs from the debounced state.
- The counter SHALL clear to 0 on any cycle where the input equals the debounced state.
- The debounced state SHALL toggle, and the counter SHALL clear, on the edge where the counter equals DEBOUNCE_CYCLES-1 and the input still differs.
REQ-014 A 0->1 transition of a debounced state SHALL produce a one-cycle registered press event; a 1->0 transition SHALL produce nothing.
REQ-015 Latency: with BTN held high from sampling edge 0, queue_level SHALL increment at edge DEBOUNCE_CYCLES+3.
REQ-016 When several press events occur in the same cycle, one SHALL be kept, in priority up > left > right > down; the rest SHALL be discarded.
REQ-017 Reference direction SHALL be the newest queued entry if queue_level > 0, else dir.
REQ-018 A candidate SHALL be rejected if it equals the reference direction or is its bitwise complement (a 180-degree reversal).
REQ-019 A 2-entry FIFO SHALL hold accepted candidates.
REQ-020 A candidate arriving while the queue is full, with no pop in the same cycle, SHALL be dropped.
REQ-021 On a cycle with mv_tick=1, pause=0 and queue_level>0:
- dir SHALL load the oldest entry.
- That entry SHALL be popped.
- dir_changed SHALL be 1 for the following cycle only.
REQ-022 mv_tick with an empty queue SHALL leave dir unchanged and SHALL NOT pulse dir_changed.
REQ-023 Simultaneous push and pop:
- Both SHALL occur.
- The reference SHALL be evaluated against the pre-pop queue.
- A full queue SHALL accept the push, and queue_level SHALL stay 2.
REQ-024 While pause=1, mv_tick SHALL be ignored, and debounce and queueing SHALL continue unchanged.
REQ-025 queue_level SHALL never exceed 2 or underflow below 0.

Reset
REQ-026 While CPU_RESETN=0, the following SHALL all be cleared:
- dir = 10 (right)
- dir_changed = 0
- queue_level = 0
- FIFO pointers, synchronizers, debounced states and counters = 0
REQ-027 A button held through reset release SHALL be treated as a fresh press and queued after REQ-015 latency if legal.
REQ-028 Reset asserted mid-debounce or with a non-empty queue SHALL discard all pending state immediately, without waiting for a clock edge.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Reset, BTN[0] high for 20 cycles, one mv_tick -> queue_level 1 at edge 7; dir 00 after the tick; dir_changed high for exactly one cycle.
REQ-030 BTN[0] glitching high 3 cycles, low 1 cycle, repeated -> no press event; queue_level stays 0.
REQ-031 dir=10, press left (01) -> rejected, queue_level 0; press down (11) then left (01) -> queue holds 11, 01; two mv_ticks -> dir 11 then 01.
REQ-032 Queue full (00, 01), third legal press with no tick -> dropped; same press coincident with mv_tick -> accepted; queue_level stays 2; dir 00.
REQ-033 pause=1, queue holds 11, mv_tick x3 -> dir stays 10; pause=0 with next tick -> dir 11.
REQ-034 BTN[0] and BTN[3] rising in the same cycle from dir=10 -> only 00 queued.
